// File: rtl/ram_dma_copy.sv
// Word-granular DMA copy engine driving one port of the dual-port simulation RAM.
// Define RAM_DMA_FILL_EN to add a constant-fill mode (ports fill_i, fill_data_i).
module ram_dma_copy #(
    parameter int unsigned ADDR_WIDTH = 16,
    parameter int unsigned LEN_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  start_i,
    input  logic [ADDR_WIDTH-1:0] src_addr_i,
    input  logic [ADDR_WIDTH-1:0] dst_addr_i,
    input  logic [LEN_WIDTH-1:0]  len_i,
    output logic                  busy_o,
    output logic                  done_o,
    output logic                  err_o,
    output logic                  mem_en_o,
    output logic [3:0]            mem_we_o,
    output logic [ADDR_WIDTH-1:0] mem_addr_o,
    output logic [31:0]           mem_data_o,
    input  logic [31:0]           mem_data_i
`ifdef RAM_DMA_FILL_EN
    ,
    input  logic                  fill_i,
    input  logic [31:0]           fill_data_i
`endif
);

    typedef enum logic [1:0] {StIdle, StRead, StWrite, StDone} state_e;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] src_q, src_d;
    logic [ADDR_WIDTH-1:0] dst_q, dst_d;
    logic [LEN_WIDTH-1:0]  cnt_q, cnt_d;
    logic                  err_q, err_d;
    logic                  fill_q;
    logic [31:0]           fill_data_q;

`ifdef RAM_DMA_FILL_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            fill_q      <= 1'b0;
            fill_data_q <= '0;
        end else if (state_q == StIdle && start_i) begin
            fill_q      <= fill_i;
            fill_data_q <= fill_data_i;
        end
    end
`else
    assign fill_q      = 1'b0;
    assign fill_data_q = '0;
`endif

    // Source alignment is irrelevant in fill mode since src is never read.
    logic misaligned;
`ifdef RAM_DMA_FILL_EN
    assign misaligned = (dst_addr_i[1:0] != 2'b00) ||
                        (!fill_i && (src_addr_i[1:0] != 2'b00));
`else
    assign misaligned = (dst_addr_i[1:0] != 2'b00) || (src_addr_i[1:0] != 2'b00);
`endif

    logic start_fill;
`ifdef RAM_DMA_FILL_EN
    assign start_fill = fill_i;
`else
    assign start_fill = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        src_d   = src_q;
        dst_d   = dst_q;
        cnt_d   = cnt_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    src_d = src_addr_i;
                    dst_d = dst_addr_i;
                    cnt_d = len_i;
                    err_d = 1'b0;
                    if (misaligned) begin
                        err_d   = 1'b1;
                        state_d = StDone;
                    end else if (len_i == '0) begin
                        state_d = StDone;
                    end else begin
                        state_d = start_fill ? StWrite : StRead;
                    end
                end
            end
            StRead: begin
                state_d = StWrite;
            end
            StWrite: begin
                src_d = src_q + ADDR_WIDTH'(4);
                dst_d = dst_q + ADDR_WIDTH'(4);
                cnt_d = cnt_q - LEN_WIDTH'(1);
                if (cnt_q == LEN_WIDTH'(1)) begin
                    state_d = StDone;
                end else begin
                    state_d = fill_q ? StWrite : StRead;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            src_q   <= '0;
            dst_q   <= '0;
            cnt_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            src_q   <= src_d;
            dst_q   <= dst_d;
            cnt_q   <= cnt_d;
            err_q   <= err_d;
        end
    end

    // All outputs decode from registered state; read data passes straight through on WRITE.
    always_comb begin
        busy_o     = (state_q != StIdle);
        done_o     = (state_q == StDone);
        err_o      = (state_q == StDone) && err_q;
        mem_en_o   = 1'b0;
        mem_we_o   = 4'b0000;
        mem_addr_o = '0;
        mem_data_o = '0;
        unique case (state_q)
            StRead: begin
                mem_en_o   = 1'b1;
                mem_addr_o = src_q;
            end
            StWrite: begin
                mem_en_o   = 1'b1;
                mem_we_o   = 4'b1111;
                mem_addr_o = dst_q;
                mem_data_o = fill_q ? fill_data_q : mem_data_i;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_ram_dma_copy.sv
// Self-checking bench for ram_dma_copy: behavioural RAM, write scoreboard, cycle counters.
// Define RAM_DMA_FILL_EN to also exercise fill mode.
module tb_ram_dma_copy;

    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [15:0] src_addr;
    logic [15:0] dst_addr;
    logic [15:0] len;
    logic        busy_o, done_o, err_o, mem_en_o;
    logic [3:0]  mem_we_o;
    logic [15:0] mem_addr_o;
    logic [31:0] mem_data_o;
    logic [31:0] rdata;
`ifdef RAM_DMA_FILL_EN
    logic        fill;
    logic [31:0] fill_data;
`endif

    always #5 clk = ~clk;

    ram_dma_copy #(.ADDR_WIDTH(16), .LEN_WIDTH(16)) dut (
        .clk        (clk),
        .reset      (reset),
        .start_i    (start),
        .src_addr_i (src_addr),
        .dst_addr_i (dst_addr),
        .len_i      (len),
        .busy_o     (busy_o),
        .done_o     (done_o),
        .err_o      (err_o),
        .mem_en_o   (mem_en_o),
        .mem_we_o   (mem_we_o),
        .mem_addr_o (mem_addr_o),
        .mem_data_o (mem_data_o),
        .mem_data_i (rdata)
`ifdef RAM_DMA_FILL_EN
        ,
        .fill_i      (fill),
        .fill_data_i (fill_data)
`endif
    );

    // RAM with registered read data and a backdoor write port for preloading.
    logic [31:0] mem     [0:16383];
    logic [31:0] exp_mem [0:16383];
    logic        bd_en = 1'b0;
    logic [15:0] bd_addr = '0;
    logic [31:0] bd_data = '0;

    always @(posedge clk) begin
        if (bd_en) begin
            mem[bd_addr[15:2]] <= bd_data;
        end else if (mem_en_o) begin
            if (mem_we_o == 4'b0000) begin
                rdata <= mem[mem_addr_o[15:2]];
            end else begin
                for (int b = 0; b < 4; b++) begin
                    if (mem_we_o[b]) mem[mem_addr_o[15:2]][b*8 +: 8] <= mem_data_o[b*8 +: 8];
                end
            end
        end
    end

    int          errors = 0;
    int          checks = 0;
    int          busy_cnt, done_cnt, err_cnt, en_cnt, rd_cnt;
    logic [47:0] exp_q[$];
    logic [47:0] got_w, exp_w;

    // Monitor: counts activity and pops the scoreboard on every observed write.
    always @(negedge clk) begin
        if (!reset) begin
            if (busy_o) busy_cnt++;
            if (done_o) done_cnt++;
            if (err_o) err_cnt++;
            if (mem_en_o) en_cnt++;
            if (mem_en_o && mem_we_o == 4'b0000) rd_cnt++;
            if (err_o) begin
                checks++;
                if (done_o !== 1'b1) begin
                    errors++;
                    $display("FAIL err_with_done: done_o=%b required 1", done_o);
                end
            end
            if (mem_en_o && mem_we_o != 4'b0000) begin
                checks++;
                got_w = {mem_addr_o, mem_data_o};
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_write: addr=%h data=%h required none",
                             mem_addr_o, mem_data_o);
                end else begin
                    exp_w = exp_q.pop_front();
                    if (got_w !== exp_w || mem_we_o !== 4'b1111) begin
                        errors++;
                        $display("FAIL write: addr/data=%h we=%b required %h we=1111",
                                 got_w, mem_we_o, exp_w);
                    end
                end
            end
        end
    end

    task automatic poke(input logic [15:0] a, input logic [31:0] d);
        @(negedge clk);
        bd_en   = 1'b1;
        bd_addr = a;
        bd_data = d;
        @(negedge clk);
        bd_en = 1'b0;
        exp_mem[a[15:2]] = d;
    endtask

    task automatic clear_counters();
        busy_cnt = 0;
        done_cnt = 0;
        err_cnt  = 0;
        en_cnt   = 0;
        rd_cnt   = 0;
    endtask

    // Reference: ascending read-then-write per word, 16-bit address wrap.
    task automatic model_copy(input logic [15:0] s, input logic [15:0] d, input int n);
        logic [31:0] w;
        for (int i = 0; i < n; i++) begin
            w = exp_mem[s[15:2]];
            exp_mem[d[15:2]] = w;
            exp_q.push_back({d, w});
            s = s + 16'd4;
            d = d + 16'd4;
        end
    endtask

    // Leaves the caller at the negedge after the start edge.
    task automatic kick(input logic [15:0] s, input logic [15:0] d, input logic [15:0] n);
        @(negedge clk);
        start    = 1'b1;
        src_addr = s;
        dst_addr = d;
        len      = n;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input string name);
        for (int k = 0; k < 200 && done_cnt == 0; k++) @(negedge clk);
        checks++;
        if (done_cnt == 0) begin
            errors++;
            $display("FAIL %s_timeout: done_cnt=0 required >0", name);
        end
        repeat (3) @(negedge clk);
    endtask

    task automatic check_mem(input string name, input logic [15:0] a, input logic [31:0] v);
        checks++;
        if (mem[a[15:2]] !== v) begin
            errors++;
            $display("FAIL %s: mem[%h]=%h required %h", name, a, mem[a[15:2]], v);
        end
    endtask

    task automatic check_int(input string name, input int got, input int req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, got, req);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++;
        if ({busy_o, done_o, err_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o} !== '0) begin
            errors++;
            $display("FAIL reset_outputs: busy=%b done=%b err=%b en=%b we=%b addr=%h data=%h required 0",
                     busy_o, done_o, err_o, mem_en_o, mem_we_o, mem_addr_o, mem_data_o);
        end
        reset = 1'b0;
        repeat (2) @(negedge clk);
        checks++;
        if ({busy_o, done_o, mem_en_o} !== 3'b000) begin
            errors++;
            $display("FAIL idle_outputs: busy=%b done=%b en=%b required 000",
                     busy_o, done_o, mem_en_o);
        end
    endtask

    task automatic test_copy4();
        for (int i = 0; i < 4; i++) begin
            poke(16'h0100 + 16'(4 * i), 32'h1111_1111 * (i + 1));
            poke(16'h0200 + 16'(4 * i), 32'h0);
        end
        model_copy(16'h0100, 16'h0200, 4);
        clear_counters();
        kick(16'h0100, 16'h0200, 16'd4);
        // A start while busy must be ignored: any write it caused would hit an empty scoreboard.
        kick(16'h0300, 16'h0300, 16'd5);
        wait_done("copy4");
        check_int("copy4_busy_cycles", busy_cnt, 9);
        check_int("copy4_done_pulses", done_cnt, 1);
        check_int("copy4_err_pulses", err_cnt, 0);
        check_int("copy4_reads", rd_cnt, 4);
        check_int("copy4_queue_left", exp_q.size(), 0);
        for (int i = 0; i < 4; i++)
            check_mem("copy4_dst", 16'h0200 + 16'(4 * i), 32'h1111_1111 * (i + 1));
    endtask

    task automatic test_misaligned();
        logic [15:0] srcs [2];
        logic [15:0] dsts [2];
        srcs[0] = 16'h0102; dsts[0] = 16'h0200;
        srcs[1] = 16'h0100; dsts[1] = 16'h0201;
        for (int t = 0; t < 2; t++) begin
            clear_counters();
            kick(srcs[t], dsts[t], 16'd3);
            checks++;
            if ({done_o, err_o} !== 2'b11) begin
                errors++;
                $display("FAIL misaligned_pulse[%0d]: done=%b err=%b required 11",
                         t, done_o, err_o);
            end
            repeat (3) @(negedge clk);
            check_int("misaligned_mem_en", en_cnt, 0);
            check_int("misaligned_busy", busy_cnt, 1);
            check_int("misaligned_done", done_cnt, 1);
        end
    endtask

    task automatic test_len_zero();
        clear_counters();
        kick(16'h0100, 16'h0200, 16'd0);
        checks++;
        if ({done_o, err_o} !== 2'b10) begin
            errors++;
            $display("FAIL len0_pulse: done=%b err=%b required 10", done_o, err_o);
        end
        repeat (3) @(negedge clk);
        check_int("len0_mem_en", en_cnt, 0);
        check_int("len0_busy", busy_cnt, 1);
        check_int("len0_err", err_cnt, 0);
    endtask

    task automatic test_wrap();
        poke(16'hFFF8, 32'hAAAA_0001);
        poke(16'hFFFC, 32'hBBBB_0002);
        poke(16'h0000, 32'hCCCC_0003);
        model_copy(16'hFFF8, 16'hFFFC, 2);
        clear_counters();
        kick(16'hFFF8, 16'hFFFC, 16'd2);
        wait_done("wrap");
        check_int("wrap_busy", busy_cnt, 5);
        check_int("wrap_queue_left", exp_q.size(), 0);
        // Overlapping ranges: 0xFFFC already holds the first word when it is read.
        check_mem("wrap_fffc", 16'hFFFC, 32'hAAAA_0001);
        check_mem("wrap_0000", 16'h0000, 32'hAAAA_0001);
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 8; i++) begin
            poke(16'h0500 + 16'(4 * i), 32'h5000_0000 + 32'(i));
            poke(16'h0600 + 16'(4 * i), 32'hDEAD_0000 + 32'(i));
        end
        model_copy(16'h0500, 16'h0600, 2);
        clear_counters();
        kick(16'h0500, 16'h0600, 16'd8);
        repeat (4) @(negedge clk);
        checks++;
        if ({mem_en_o, mem_we_o, mem_addr_o} !== {1'b1, 4'b0000, 16'h0508}) begin
            errors++;
            $display("FAIL mid_third_read: en=%b we=%b addr=%h required 1 0000 0508",
                     mem_en_o, mem_we_o, mem_addr_o);
        end
        reset = 1'b1;
        @(negedge clk);
        checks++;
        if ({busy_o, mem_en_o, done_o} !== 3'b000) begin
            errors++;
            $display("FAIL mid_after_reset: busy=%b en=%b done=%b required 000",
                     busy_o, mem_en_o, done_o);
        end
        reset = 1'b0;
        repeat (5) @(negedge clk);
        check_int("mid_done_pulses", done_cnt, 0);
        check_int("mid_queue_left", exp_q.size(), 0);
        for (int i = 0; i < 8; i++)
            check_mem("mid_dst", 16'h0600 + 16'(4 * i),
                      (i < 2) ? 32'h5000_0000 + 32'(i) : 32'hDEAD_0000 + 32'(i));
        model_copy(16'h0500, 16'h0700, 3);
        clear_counters();
        kick(16'h0500, 16'h0700, 16'd3);
        wait_done("recopy");
        check_int("recopy_busy", busy_cnt, 7);
        check_int("recopy_queue_left", exp_q.size(), 0);
        for (int i = 0; i < 3; i++)
            check_mem("recopy_dst", 16'h0700 + 16'(4 * i), 32'h5000_0000 + 32'(i));
    endtask

`ifdef RAM_DMA_FILL_EN
    task automatic test_fill();
        for (int i = 0; i < 3; i++) begin
            exp_q.push_back({16'h0400 + 16'(4 * i), 32'hDEAD_BEEF});
            exp_mem[(16'h0400 >> 2) + i] = 32'hDEAD_BEEF;
        end
        clear_counters();
        fill      = 1'b1;
        fill_data = 32'hDEAD_BEEF;
        // Misaligned src must be ignored in fill mode.
        kick(16'h0003, 16'h0400, 16'd3);
        fill = 1'b0;
        wait_done("fill");
        check_int("fill_busy", busy_cnt, 4);
        check_int("fill_reads", rd_cnt, 0);
        check_int("fill_err", err_cnt, 0);
        check_int("fill_queue_left", exp_q.size(), 0);
        for (int i = 0; i < 3; i++) check_mem("fill_dst", 16'h0400 + 16'(4 * i), 32'hDEAD_BEEF);
    endtask
`endif

    initial begin
        start    = 1'b0;
        src_addr = '0;
        dst_addr = '0;
        len      = '0;
`ifdef RAM_DMA_FILL_EN
        fill      = 1'b0;
        fill_data = '0;
`endif
        clear_counters();
        test_reset();
        test_copy4();
        test_misaligned();
        test_len_zero();
        test_wrap();
        test_reset_mid();
`ifdef RAM_DMA_FILL_EN
        test_fill();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
